// File: rtl/vga_timing_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_timing_detect : measures incoming sync geometry, reports lock and
//                     regenerates active-pixel column/row coordinates.
// Revision          : 1.0
// ----------------------------------------------------------------------------
module vga_timing_detect #(
  parameter int WIDTH = 12,
  parameter bit HPOL  = 1'b0,
  parameter bit VPOL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             blank,
  output logic             active,
  output logic [WIDTH-1:0] hdata,
  output logic [WIDTH-1:0] vdata,
  output logic             line_start,
  output logic             frame_start,
  output logic [WIDTH-1:0] htotal,
  output logic [WIDTH-1:0] hactive,
  output logic [WIDTH-1:0] vtotal,
  output logic [WIDTH-1:0] vactive,
  output logic             locked
);

  localparam logic [WIDTH-1:0] C_MAX = '1;
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    FIRST   = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_hs1, r_vs1, r_de1;
  logic             r_hs2, r_vs2, r_de2;
  logic [WIDTH-1:0] r_hcnt, r_xcnt, r_lcnt, r_ycnt;
  logic [WIDTH-1:0] r_htotal_cur, r_hactive_cur;
  logic [WIDTH-1:0] r_ref_htotal, r_ref_hactive, r_ref_vtotal, r_ref_vactive;

  logic             w_hs_edge, w_vs_edge, w_de_fall;
  logic [WIDTH-1:0] w_htotal_new, w_vtotal_new;
  logic             w_sat, w_match, w_lost;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] x);
    return (x == C_MAX) ? x : x + C_ONE;
  endfunction

  assign w_hs_edge    = r_hs1 & ~r_hs2;
  assign w_vs_edge    = r_vs1 & ~r_vs2;
  assign w_de_fall    = ~r_de1 & r_de2;
  assign w_htotal_new = sat_inc(r_hcnt);
  // A line edge coinciding with the frame edge belongs to the closing frame.
  assign w_vtotal_new = w_hs_edge ? sat_inc(r_lcnt) : r_lcnt;
  assign w_sat        = (r_hcnt == C_MAX) | (r_lcnt == C_MAX);

  assign w_match = (r_htotal_cur == r_ref_htotal) && (r_hactive_cur == r_ref_hactive) &&
                   (w_vtotal_new == r_ref_vtotal) && (r_ycnt == r_ref_vactive);
  assign w_lost  = (w_hs_edge && (w_htotal_new != htotal)) ||
                   (w_vs_edge && ((w_vtotal_new != vtotal) || (r_ycnt != vactive)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs1 <= 1'b0;
      r_vs1 <= 1'b0;
      r_de1 <= 1'b0;
      r_hs2 <= 1'b0;
      r_vs2 <= 1'b0;
      r_de2 <= 1'b0;
    end else begin
      r_hs1 <= (hsync == HPOL);
      r_vs1 <= (vsync == VPOL);
      r_de1 <= ~blank;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_de2 <= r_de1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt        <= '0;
      r_xcnt        <= '0;
      r_lcnt        <= '0;
      r_ycnt        <= '0;
      r_htotal_cur  <= '0;
      r_hactive_cur <= '0;
    end else begin
      r_hcnt <= w_hs_edge ? '0 : sat_inc(r_hcnt);
      if (w_hs_edge) r_htotal_cur <= w_htotal_new;

      if (w_hs_edge)  r_xcnt <= '0;
      else if (r_de1) r_xcnt <= sat_inc(r_xcnt);
      if (w_de_fall)  r_hactive_cur <= r_xcnt;

      if (w_vs_edge)      r_lcnt <= '0;
      else if (w_hs_edge) r_lcnt <= sat_inc(r_lcnt);

      if (w_vs_edge)      r_ycnt <= '0;
      else if (w_de_fall) r_ycnt <= sat_inc(r_ycnt);
    end
  end

  // Coordinates are the pre-increment counts and freeze during blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      active      <= 1'b0;
      hdata       <= '0;
      vdata       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      active      <= r_de1;
      line_start  <= w_hs_edge;
      frame_start <= w_vs_edge;
      if (r_de1) begin
        hdata <= r_xcnt;
        vdata <= r_ycnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= SEARCH;
      locked        <= 1'b0;
      r_ref_htotal  <= '0;
      r_ref_hactive <= '0;
      r_ref_vtotal  <= '0;
      r_ref_vactive <= '0;
      htotal        <= '0;
      hactive       <= '0;
      vtotal        <= '0;
      vactive       <= '0;
    end else if (w_sat) begin
      r_state <= SEARCH;
      locked  <= 1'b0;
    end else begin
      case (r_state)
        SEARCH: begin
          if (w_vs_edge) r_state <= FIRST;
        end
        FIRST: begin
          if (w_vs_edge) begin
            r_ref_htotal  <= r_htotal_cur;
            r_ref_hactive <= r_hactive_cur;
            r_ref_vtotal  <= w_vtotal_new;
            r_ref_vactive <= r_ycnt;
            r_state       <= MEASURE;
          end
        end
        MEASURE: begin
          if (w_vs_edge) begin
            if (w_match) begin
              r_state <= LOCKED;
              locked  <= 1'b1;
              htotal  <= r_ref_htotal;
              hactive <= r_ref_hactive;
              vtotal  <= r_ref_vtotal;
              vactive <= r_ref_vactive;
            end else begin
              r_ref_htotal  <= r_htotal_cur;
              r_ref_hactive <= r_hactive_cur;
              r_ref_vtotal  <= w_vtotal_new;
              r_ref_vactive <= r_ycnt;
            end
          end
        end
        LOCKED: begin
          if (w_lost) begin
            r_state <= SEARCH;
            locked  <= 1'b0;
          end
        end
        default: begin
          r_state <= SEARCH;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
